// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared funct3 length codes, FSM states and counter sizing for the memory stage
package mem_stage_pkg;
  localparam logic [2:0] LEN_B  = 3'b000;
  localparam logic [2:0] LEN_H  = 3'b001;
  localparam logic [2:0] LEN_W  = 3'b010;
  localparam logic [2:0] LEN_BU = 3'b100;
  localparam logic [2:0] LEN_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic int cnt_width(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction
endpackage

// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: req/ack data bus between the memory stage (master) and memory (slave)
interface mem_stage_lsu_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  modport master (output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, input bus_rdata, bus_ack);
  modport slave  (input bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, output bus_rdata, bus_ack);
endinterface

// File: rtl/load_formatter.sv
// load_formatter: picks the addressed byte/half lane of a read word and sign- or zero-extends it
module load_formatter
  import mem_stage_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_len,
  output logic [31:0] o_result
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  assign w_byte = i_rdata[{i_addr, 3'b000} +: 8];
  assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
  // any length code that is not a byte or half form reads the whole word
  always_comb
    o_result = (i_len == LEN_B)  ? {{24{w_byte[7]}}, w_byte} :
               (i_len == LEN_BU) ? {24'b0, w_byte} :
               (i_len == LEN_H)  ? {{16{w_half[15]}}, w_half} :
               (i_len == LEN_HU) ? {16'b0, w_half} : i_rdata;
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: RV32 memory stage issuing loads/stores on a req/ack bus with stall, alignment and timeout handling
module mem_stage_lsu
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [31:0]           mem_result,
  input  logic [31:0]           mem_rs2_data_forwarded,
  input  logic [4:0]            mem_rd,
  input  logic                  mem_reg_write,
  input  logic                  mem_mem_write,
  input  logic                  mem_mem_read,
  input  logic [2:0]            mem_mem_op_length,
  mem_stage_lsu_if.master       bus,
  output logic [31:0]           wb_result,
  output logic [4:0]            wb_rd,
  output logic                  wb_reg_write,
  output logic                  stall,
  output logic                  fault_misaligned,
  output logic                  fault_timeout
);
  localparam int CW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  state_t      r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic        r_to, r_req, r_we;
  logic [31:0] r_rdata, r_addr, r_wdata;
  logic [3:0]  r_wstrb;
  logic [2:0]  r_len;
  logic [1:0]  r_off;
  logic        w_op, w_mis, w_start, w_expire;
  logic [1:0]  w_sz;
  logic [31:0] w_wdata, w_fmt;
  logic [3:0]  w_strb;
  assign w_sz     = mem_mem_op_length[1:0];
  assign w_op     = mem_mem_read | mem_mem_write;
  assign w_mis    = w_op & ((w_sz == LEN_H[1:0]) ? mem_result[0] : (w_sz != LEN_B[1:0]) & (|mem_result[1:0]));
  assign w_start  = (r_state == IDLE) & w_op & ~w_mis;
  assign w_expire = (TIMEOUT_CYCLES != 0) && (r_cnt == T_LAST);
  assign w_wdata  = (w_sz == LEN_B[1:0]) ? {4{mem_rs2_data_forwarded[7:0]}} :
                    (w_sz == LEN_H[1:0]) ? {2{mem_rs2_data_forwarded[15:0]}} : mem_rs2_data_forwarded;
  assign w_strb   = !mem_mem_write ? 4'b0000 :
                    (w_sz == LEN_B[1:0]) ? 4'b0001 << mem_result[1:0] :
                    (w_sz == LEN_H[1:0]) ? 4'b0011 << {mem_result[1], 1'b0} : 4'b1111;
  load_formatter u_fmt (.i_rdata(r_rdata), .i_addr(r_off), .i_len(r_len), .o_result(w_fmt));
  assign bus.bus_req   = r_req;
  assign bus.bus_we    = r_we;
  assign bus.bus_addr  = r_addr;
  assign bus.bus_wdata = r_wdata;
  assign bus.bus_wstrb = r_wstrb;
  assign wb_rd         = mem_rd;
  assign fault_timeout = (r_state == DONE) & r_to;
  // state, timeout counter, captured request and read data; reset drops an in-flight request at once
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_to    <= 1'b0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
      r_len   <= '0;
      r_off   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == BUSY) ? r_cnt + 1'b1 : '0;
      r_to    <= (r_state == BUSY) & ~bus.bus_ack & w_expire;
      r_req   <= w_start | ((r_state == BUSY) & ~bus.bus_ack & ~w_expire);
      if ((r_state == BUSY) && bus.bus_ack) r_rdata <= bus.bus_rdata;
      if (w_start) begin
        r_addr  <= {mem_result[31:2], 2'b00};
        r_we    <= mem_mem_write;
        r_wdata <= w_wdata;
        r_wstrb <= w_strb;
        r_len   <= mem_mem_op_length;
        r_off   <= mem_result[1:0];
      end
    end
  // next state and writeback/stall/fault outputs; an ack wins over a timeout in the same cycle
  always_comb begin
    w_next           = r_state;
    stall            = 1'b0;
    wb_reg_write     = 1'b0;
    wb_result        = '0;
    fault_misaligned = 1'b0;
    unique case (r_state)
      IDLE: begin
        fault_misaligned = w_mis;
        stall            = w_start;
        w_next           = w_start ? BUSY : IDLE;
        wb_result        = w_op ? '0 : mem_result;
        wb_reg_write     = ~w_op & mem_reg_write;
      end
      BUSY: begin
        stall  = 1'b1;
        w_next = (bus.bus_ack || w_expire) ? DONE : BUSY;
      end
      DONE: begin
        w_next       = IDLE;
        wb_result    = r_to ? '0 : r_we ? mem_result : w_fmt;
        wb_reg_write = ~r_to & mem_reg_write;
      end
      default: w_next = IDLE;
    endcase
    if (!reset_n) begin
      stall            = 1'b0;
      wb_reg_write     = 1'b0;
      fault_misaligned = 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed and randomized checks of the memory stage against a lane/extension model
module tb_mem_stage_lsu;
  localparam int TO = 4;
  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] mem_result, mem_rs2_data_forwarded;
  logic [4:0]  mem_rd;
  logic        mem_reg_write, mem_mem_write, mem_mem_read;
  logic [2:0]  mem_mem_op_length;
  logic [31:0] wb_result;
  logic [4:0]  wb_rd;
  logic        wb_reg_write, stall, fault_misaligned, fault_timeout;
  int          total = 0;
  int          bad = 0;
  mem_stage_lsu_if bus_if ();
  mem_stage_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset_n(reset_n),
    .mem_result(mem_result), .mem_rs2_data_forwarded(mem_rs2_data_forwarded),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_write(mem_mem_write),
    .mem_mem_read(mem_mem_read), .mem_mem_op_length(mem_mem_op_length),
    .bus(bus_if.master),
    .wb_result(wb_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .stall(stall), .fault_misaligned(fault_misaligned), .fault_timeout(fault_timeout)
  );
  always #5 clock = ~clock;

  task automatic chk(input string t, input string n, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s observed=0x%08h expected=0x%08h", t, n, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f);
    return (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [31:0] a, input logic [2:0] f);
    int sz;
    logic [31:0] m, v;
    sz = size_of(f);
    if (sz == 4) return rd;
    m = (32'd1 << (8 * sz)) - 32'd1;
    v = (rd >> (8 * (a % 32'd4))) & m;
    if (!f[2] && v[8*sz-1]) v = v | ~m;
    return v;
  endfunction

  task automatic idle_inputs();
    mem_mem_read  = 1'b0;
    mem_mem_write = 1'b0;
    mem_reg_write = 1'b0;
    mem_result    = $urandom;
  endtask

  task automatic do_op(input string t, input logic rdf, input logic wrf, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] rs2, input logic rwf, input logic [4:0] rd,
                       input int d, input logic [31:0] rdat, input logic stray);
    int sz, n;
    logic op, mis, timed;
    logic [31:0] wd, st;
    op  = rdf | wrf;
    sz  = size_of(f);
    mis = op && ((a % 32'(sz)) != 0);
    mem_result = a; mem_rs2_data_forwarded = rs2; mem_rd = rd; mem_reg_write = rwf;
    mem_mem_read = rdf; mem_mem_write = wrf; mem_mem_op_length = f; bus_if.bus_ack = stray;
    #1;
    chk(t, "wb_rd", 32'(wb_rd), 32'(rd));
    chk(t, "idle_req", 32'(bus_if.bus_req), 32'd0);
    chk(t, "idle_mis", 32'(fault_misaligned), 32'(mis));
    chk(t, "idle_stall", 32'(stall), 32'(op && !mis));
    if (!op || mis) begin
      chk(t, "idle_wb", wb_result, op ? 32'd0 : a);
      chk(t, "idle_wbe", 32'(wb_reg_write), op ? 32'd0 : 32'(rwf));
      idle_inputs();
      bus_if.bus_ack = 1'b0;
      @(posedge clock); #1;
      chk(t, "after_req", 32'(bus_if.bus_req), 32'd0);
      chk(t, "after_mis", 32'(fault_misaligned), 32'd0);
      return;
    end
    wd = (sz == 1) ? (rs2 & 32'hFF) * 32'h01010101 : (sz == 2) ? (rs2 & 32'hFFFF) * 32'h00010001 : rs2;
    st = ((32'd1 << sz) - 32'd1) << (a % 32'd4);
    timed = d >= TO;
    n = timed ? TO : d + 1;
    @(posedge clock); #1;
    bus_if.bus_ack = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk(t, "busy_req", 32'(bus_if.bus_req), 32'd1);
      chk(t, "busy_stall", 32'(stall), 32'd1);
      chk(t, "busy_addr", bus_if.bus_addr, a & ~32'd3);
      chk(t, "busy_we", 32'(bus_if.bus_we), 32'(wrf));
      if (wrf) begin
        chk(t, "busy_wdata", bus_if.bus_wdata, wd);
        chk(t, "busy_wstrb", 32'(bus_if.bus_wstrb), st);
      end
      if (i == d) begin
        bus_if.bus_ack = 1'b1;
        bus_if.bus_rdata = rdat;
      end
      @(posedge clock); #1;
      bus_if.bus_ack = 1'b0;
      bus_if.bus_rdata = $urandom;
    end
    chk(t, "done_req", 32'(bus_if.bus_req), 32'd0);
    chk(t, "done_stall", 32'(stall), 32'd0);
    chk(t, "done_fto", 32'(fault_timeout), 32'(timed));
    chk(t, "done_wbe", 32'(wb_reg_write), timed ? 32'd0 : 32'(rwf));
    chk(t, "done_wb", wb_result, timed ? 32'd0 : wrf ? a : ref_load(rdat, a, f));
    idle_inputs();
    @(posedge clock); #1;
    chk(t, "post_fto", 32'(fault_timeout), 32'd0);
    chk(t, "post_req", 32'(bus_if.bus_req), 32'd0);
    chk(t, "post_stall", 32'(stall), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
    mem_result = 32'h0000_4000; mem_rs2_data_forwarded = '0; mem_rd = 5'd1; mem_reg_write = 1'b1;
    mem_mem_read = 1'b1; mem_mem_write = 1'b0; mem_mem_op_length = 3'b010;
    repeat (3) @(posedge clock);
    #1;
    chk("reset", "req", 32'(bus_if.bus_req), 32'd0);
    chk("reset", "we", 32'(bus_if.bus_we), 32'd0);
    chk("reset", "addr", bus_if.bus_addr, 32'd0);
    chk("reset", "wdata", bus_if.bus_wdata, 32'd0);
    chk("reset", "wstrb", 32'(bus_if.bus_wstrb), 32'd0);
    chk("reset", "stall", 32'(stall), 32'd0);
    chk("reset", "wbe", 32'(wb_reg_write), 32'd0);
    chk("reset", "faults", {30'd0, fault_misaligned, fault_timeout}, 32'd0);
    idle_inputs();
    reset_n = 1'b1;
    @(posedge clock); #1;

    do_op("alu", 1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 1'b1, 5'd5, 0, 32'h0, 1'b0);
    do_op("lb", 1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 1'b1, 5'd7, 2, 32'h80FF_FFFF, 1'b0);
    do_op("lbu", 1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'h0, 1'b1, 5'd7, 2, 32'h80FF_FFFF, 1'b0);
    do_op("sh", 1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'hABCD_1234, 1'b0, 5'd0, 0, 32'h0, 1'b0);
    do_op("lw_mis", 1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0, 1'b1, 5'd9, 0, 32'h0, 1'b0);
    do_op("lw_to", 1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0, 1'b1, 5'd3, 99, 32'h0, 1'b0);
    do_op("lh_stray", 1'b1, 1'b0, 3'b001, 32'h0000_6002, 32'h0, 1'b1, 5'd4, 1, 32'h8001_7FFF, 1'b1);
    do_op("both_sb", 1'b1, 1'b1, 3'b000, 32'h0000_7001, 32'h0000_00A5, 1'b1, 5'd2, 0, 32'h0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      logic [2:0] f;
      logic [31:0] a;
      f = 3'($urandom_range(0, 7));
      a = {$urandom} & ~32'd3 | 32'($urandom_range(0, 3));
      do_op("rand", 1'($urandom), 1'($urandom), f, a, $urandom, 1'($urandom), 5'($urandom),
            $urandom_range(0, 5), $urandom, 1'($urandom_range(0, 3) == 0));
    end

    mem_result = 32'h0000_8000; mem_rd = 5'd6; mem_reg_write = 1'b1;
    mem_mem_read = 1'b1; mem_mem_write = 1'b0; mem_mem_op_length = 3'b010;
    @(posedge clock); #1;
    chk("rst_busy", "req1", 32'(bus_if.bus_req), 32'd1);
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    chk("rst_busy", "req", 32'(bus_if.bus_req), 32'd0);
    chk("rst_busy", "stall", 32'(stall), 32'd0);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hDEAD_BEEF;
    @(posedge clock); #1;
    bus_if.bus_ack = 1'b0;
    chk("rst_busy", "req_hold", 32'(bus_if.bus_req), 32'd0);
    chk("rst_busy", "faults", {30'd0, fault_misaligned, fault_timeout}, 32'd0);
    idle_inputs();
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("rst_busy", "post_req", 32'(bus_if.bus_req), 32'd0);
    chk("rst_busy", "post_faults", {30'd0, fault_misaligned, fault_timeout}, 32'd0);
    do_op("rst_post", 1'b0, 1'b0, 3'b000, 32'h0000_0042, 32'h0, 1'b1, 5'd11, 0, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
